mi_cmd_master: RTL
==================

Name: mi_cmd_master

Overview:
- MI32 initiator: converts a command stream into MI bus transactions toward MI-slave blocks such as the MVB channel router configuration port.
- Returns read data on a response stream.
- Handles one transaction at a time, with a DRDY timeout and in-order responses.
- Sits between a management/host command source and a local MI slave.

Parameters:
- MI_DATA_WIDTH, 32, width of MI_DWR/MI_DRD/CMD_DWR/RSP_DATA.
- MI_ADDR_WIDTH, 32, width of MI_ADDR/CMD_ADDR.
- TIMEOUT, 256, cycles to wait for MI_DRDY after read accept; must be >=2.
- CNT_WIDTH, 32, width of statistics counters.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CMD_ADDR  in  MI_ADDR_WIDTH  transaction address.
- CMD_DWR  in  MI_DATA_WIDTH  write data.
- CMD_BE  in  MI_DATA_WIDTH/8  byte enables.
- CMD_WR  in  1  1=write, 0=read.
- CMD_SRC_RDY  in  1  command valid.
- CMD_DST_RDY  out  1  command accepted.
- MI_DWR  out  MI_DATA_WIDTH  MI write data.
- MI_ADDR  out  MI_ADDR_WIDTH  MI address.
- MI_BE  out  MI_DATA_WIDTH/8  MI byte enables.
- MI_RD  out  1  MI read request.
- MI_WR  out  1  MI write request.
- MI_ARDY  in  1  slave accepted request.
- MI_DRD  in  MI_DATA_WIDTH  read data.
- MI_DRDY  in  1  read data valid.
- RSP_DATA  out  MI_DATA_WIDTH  read result.
- RSP_ERR  out  1  1=read timed out.
- RSP_SRC_RDY  out  1  response valid.
- RSP_DST_RDY  in  1  response consumer ready.
- STAT_RD_CNT, STAT_WR_CNT, STAT_TO_CNT  out  CNT_WIDTH each  statistics (see Optional Feature).

Behaviour:
- Reset values:
  - MI_RD=MI_WR=0, CMD_DST_RDY=0, RSP_SRC_RDY=0, RSP_ERR=0.
  - RSP_DATA, MI_ADDR, MI_DWR, MI_BE = 0.
  - stale flag=0, timeout counter=0, statistics=0.
  - FSM=IDLE.
- FSM states: IDLE, REQ, WAIT_DRDY, RSP.
- IDLE:
  - CMD_DST_RDY=1 only in IDLE.
  - On CMD_SRC_RDY=1, register ADDR/DWR/BE/WR and go to REQ. MI_RD or MI_WR is asserted in the next cycle, so command-accept to MI request latency is 1 cycle.
- REQ:
  - MI_RD=!WR, MI_WR=WR; address, data and BE are held stable until MI_ARDY=1.
  - On MI_ARDY: a write returns to IDLE (no response); a read goes to WAIT_DRDY with timeout counter=0.
  - A read whose MI_DRDY arrives in the same cycle as MI_ARDY captures MI_DRD and goes directly to RSP.
  - No ARDY timeout; the request is held indefinitely.
- WAIT_DRDY:
  - The counter increments each cycle.
  - On MI_DRDY (stale=0): RSP_DATA<=MI_DRD, RSP_ERR<=0, go to RSP.
  - When the counter reaches TIMEOUT-1 without DRDY: RSP_DATA<=0, RSP_ERR<=1, stale<=1, go to RSP.
  - DRDY in the same cycle as the timeout wins: the data is valid and stale stays 0.
- RSP:
  - RSP_SRC_RDY=1; data and error are held until RSP_DST_RDY=1, then go to IDLE.
- Stale DRDY handling:
  - While stale=1, the first MI_DRDY pulse, in any state, is discarded and clears stale.
  - A new read may be issued while stale=1. Its WAIT_DRDY ignores that one stale pulse and waits for the next pulse, with the counter restarted.
  - At most one stale pulse is tracked.
- MI_DRDY while no read is outstanding and stale=0 is ignored.
- Reset mid-operation:
  - All state returns immediately to reset values.
  - The pending command and response are lost.
  - MI_RD/MI_WR drop asynchronously.

Optional Feature:
- Macro MI_CMD_MASTER_STATS_EN.
- Defined:
  - STAT_RD_CNT increments on each read ARDY handshake.
  - STAT_WR_CNT increments on each write ARDY handshake.
  - STAT_TO_CNT increments on each timeout.
  - Counters wrap modulo 2^CNT_WIDTH and are cleared by RESET.
- Undefined: STAT_* outputs are constant 0 and no counter logic is synthesized.

Test Plan:
- Write ADDR=0x10, DWR=0xA5A5A5A5, BE=0xF; slave holds ARDY low for 3 cycles:
  - MI_WR=1 for exactly 4 cycles with stable fields.
  - No response is produced.
  - CMD_DST_RDY returns 1 one cycle after ARDY.
- Read ADDR=0x04; ARDY in 1 cycle, DRDY 2 cycles later with DRD=0x12345678:
  - RSP_DATA=0x12345678, RSP_ERR=0.
  - Response held while RSP_DST_RDY=0 for 5 cycles.
- Read with ARDY and DRDY in the same cycle, DRD=0xCAFEF00D:
  - Response valid the next cycle with that data.
- Read with TIMEOUT=8 and no DRDY:
  - RSP_ERR=1, RSP_DATA=0 after 8 cycles in WAIT_DRDY.
  - A late DRDY(0x1111) is dropped.
  - A following read returning 0x2222 yields RSP_DATA=0x2222.
- Read, then assert RESET while in WAIT_DRDY:
  - MI_RD=0 and RSP_SRC_RDY=0 immediately.
  - Next command is accepted normally.
- With MI_CMD_MASTER_STATS_EN:
  - 3 writes, 2 reads, 1 timeout give STAT_WR_CNT=3, STAT_RD_CNT=2, STAT_TO_CNT=1.
  - Without the macro all STAT_* = 0.

Source files
------------

// File: rtl/mi_cmd_master_if.sv
// mi_cmd_master_if: groups the command, MI bus and response signals of the MI32 command
// master into one bundle.
//   Parameters: MI_DATA_WIDTH (data bus width), MI_ADDR_WIDTH (address width).
//   Command side : cmd_addr, cmd_dwr, cmd_be, cmd_wr, cmd_src_rdy -> / <- cmd_dst_rdy
//   MI side      : mi_dwr, mi_addr, mi_be, mi_rd, mi_wr -> / <- mi_ardy, mi_drd, mi_drdy
//   Response side: rsp_data, rsp_err, rsp_src_rdy -> / <- rsp_dst_rdy
//   modport master: the command master block itself.
//   modport slave : the surrounding environment (command source, MI slave, response sink).
interface mi_cmd_master_if #(
  parameter int unsigned MI_DATA_WIDTH = 32,
  parameter int unsigned MI_ADDR_WIDTH = 32
);
  localparam int unsigned BeW = MI_DATA_WIDTH / 8;

  logic [MI_ADDR_WIDTH-1:0] cmd_addr;
  logic [MI_DATA_WIDTH-1:0] cmd_dwr;
  logic [BeW-1:0]           cmd_be;
  logic                     cmd_wr;
  logic                     cmd_src_rdy;
  logic                     cmd_dst_rdy;

  logic [MI_DATA_WIDTH-1:0] mi_dwr;
  logic [MI_ADDR_WIDTH-1:0] mi_addr;
  logic [BeW-1:0]           mi_be;
  logic                     mi_rd;
  logic                     mi_wr;
  logic                     mi_ardy;
  logic [MI_DATA_WIDTH-1:0] mi_drd;
  logic                     mi_drdy;

  logic [MI_DATA_WIDTH-1:0] rsp_data;
  logic                     rsp_err;
  logic                     rsp_src_rdy;
  logic                     rsp_dst_rdy;

  modport master (
    input  cmd_addr, cmd_dwr, cmd_be, cmd_wr, cmd_src_rdy,
    output cmd_dst_rdy,
    output mi_dwr, mi_addr, mi_be, mi_rd, mi_wr,
    input  mi_ardy, mi_drd, mi_drdy,
    output rsp_data, rsp_err, rsp_src_rdy,
    input  rsp_dst_rdy
  );

  modport slave (
    output cmd_addr, cmd_dwr, cmd_be, cmd_wr, cmd_src_rdy,
    input  cmd_dst_rdy,
    input  mi_dwr, mi_addr, mi_be, mi_rd, mi_wr,
    output mi_ardy, mi_drd, mi_drdy,
    input  rsp_data, rsp_err, rsp_src_rdy,
    output rsp_dst_rdy
  );
endinterface

// File: rtl/mi_cmd_master.sv
// mi_cmd_master: MI32 initiator. Takes one command at a time from a command stream, runs it
// as an MI read or write, and returns read results (or a timeout error) on a response stream.
//
// Parameters:
//   MI_DATA_WIDTH  data width of MI/command/response data (default 32)
//   MI_ADDR_WIDTH  address width (default 32)
//   TIMEOUT        cycles to wait for mi_drdy after a read is accepted; must be >= 2
//   CNT_WIDTH      width of the statistics counters
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous active-high reset
//   bus            mi_cmd_master_if.master: command, MI and response signals
//   stat_rd_cnt    read ARDY handshakes    (statistics build only, else 0)
//   stat_wr_cnt    write ARDY handshakes   (statistics build only, else 0)
//   stat_to_cnt    read timeouts           (statistics build only, else 0)
// Build option:
//   MI_CMD_MASTER_STATS_EN  when defined, the three statistics counters are implemented;
//                           otherwise the stat outputs are tied to zero.
module mi_cmd_master #(
  parameter int unsigned MI_DATA_WIDTH = 32,
  parameter int unsigned MI_ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT       = 256,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  mi_cmd_master_if.master        bus,
  output logic [CNT_WIDTH-1:0]   stat_rd_cnt,
  output logic [CNT_WIDTH-1:0]   stat_wr_cnt,
  output logic [CNT_WIDTH-1:0]   stat_to_cnt
);

  localparam int unsigned BeW = MI_DATA_WIDTH / 8;
  localparam int unsigned ToW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitDrdy,
    StRsp
  } state_e;

  state_e state_q, state_d;

  // Registered command
  logic [MI_ADDR_WIDTH-1:0] addr_q;
  logic [MI_DATA_WIDTH-1:0] dwr_q;
  logic [BeW-1:0]           be_q;
  logic                     wr_q;

  // Response holding registers
  logic [MI_DATA_WIDTH-1:0] rsp_data_q;
  logic                     rsp_err_q;

  // Set on a read timeout: the slave still owes one mi_drdy pulse that must not be
  // mistaken for the answer to a later read.
  logic stale_q, stale_d;

  logic [ToW-1:0] to_cnt_q, to_cnt_d;

  // Events decoded by the next-state logic
  logic cmd_take;
  logic rd_hs;
  logic wr_hs;
  logic rsp_load_data;
  logic rsp_load_err;

  logic drdy_live;
  logic drdy_stale;

  assign drdy_live  = bus.mi_drdy & ~stale_q;
  assign drdy_stale = bus.mi_drdy & stale_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic (also produces datapath strobes)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cmd_take      = 1'b0;
    rd_hs         = 1'b0;
    wr_hs         = 1'b0;
    rsp_load_data = 1'b0;
    rsp_load_err  = 1'b0;
    to_cnt_d      = to_cnt_q;
    stale_d       = stale_q;

    // The owed pulse is swallowed wherever it shows up.
    if (drdy_stale) begin
      stale_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (bus.cmd_src_rdy) begin
          cmd_take = 1'b1;
          state_d  = StReq;
        end
      end

      StReq: begin
        if (bus.mi_ardy) begin
          if (wr_q) begin
            wr_hs   = 1'b1;
            state_d = StIdle;
          end else begin
            rd_hs    = 1'b1;
            to_cnt_d = '0;
            if (drdy_live) begin
              rsp_load_data = 1'b1;
              state_d       = StRsp;
            end else begin
              state_d = StWaitDrdy;
            end
          end
        end
      end

      StWaitDrdy: begin
        if (drdy_live) begin
          // Checked before the timeout so a coincident pulse still delivers data.
          rsp_load_data = 1'b1;
          state_d       = StRsp;
        end else if (drdy_stale) begin
          // Pulse belonged to the earlier timed-out read; give this read a full window.
          to_cnt_d = '0;
        end else if (to_cnt_q == ToLast) begin
          rsp_load_err = 1'b1;
          stale_d      = 1'b1;
          state_d      = StRsp;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      StRsp: begin
        if (bus.rsp_dst_rdy) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (from state only, so reset drops requests asynchronously)
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.cmd_dst_rdy = 1'b0;
    bus.mi_rd       = 1'b0;
    bus.mi_wr       = 1'b0;
    bus.rsp_src_rdy = 1'b0;
    case (state_q)
      // Held low while reset is asserted even though the state register reads idle.
      StIdle:     bus.cmd_dst_rdy = ~reset;
      StReq: begin
        bus.mi_rd = ~wr_q;
        bus.mi_wr = wr_q;
      end
      StWaitDrdy: ;
      StRsp:      bus.rsp_src_rdy = 1'b1;
      default:    ;
    endcase
  end

  assign bus.mi_addr  = addr_q;
  assign bus.mi_dwr   = dwr_q;
  assign bus.mi_be    = be_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err  = rsp_err_q;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      dwr_q      <= '0;
      be_q       <= '0;
      wr_q       <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      stale_q    <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      stale_q  <= stale_d;
      to_cnt_q <= to_cnt_d;
      if (cmd_take) begin
        addr_q <= bus.cmd_addr;
        dwr_q  <= bus.cmd_dwr;
        be_q   <= bus.cmd_be;
        wr_q   <= bus.cmd_wr;
      end
      if (rsp_load_data) begin
        rsp_data_q <= bus.mi_drd;
        rsp_err_q  <= 1'b0;
      end else if (rsp_load_err) begin
        rsp_data_q <= '0;
        rsp_err_q  <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef MI_CMD_MASTER_STATS_EN
  logic [CNT_WIDTH-1:0] stat_rd_q;
  logic [CNT_WIDTH-1:0] stat_wr_q;
  logic [CNT_WIDTH-1:0] stat_to_q;

  // Counters wrap naturally at 2^CNT_WIDTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
      stat_to_q <= '0;
    end else begin
      if (rd_hs) begin
        stat_rd_q <= stat_rd_q + 1'b1;
      end
      if (wr_hs) begin
        stat_wr_q <= stat_wr_q + 1'b1;
      end
      if (rsp_load_err) begin
        stat_to_q <= stat_to_q + 1'b1;
      end
    end
  end

  assign stat_rd_cnt = stat_rd_q;
  assign stat_wr_cnt = stat_wr_q;
  assign stat_to_cnt = stat_to_q;
`else
  assign stat_rd_cnt = '0;
  assign stat_wr_cnt = '0;
  assign stat_to_cnt = '0;

  logic unused_stat_events;
  assign unused_stat_events = ^{rd_hs, wr_hs};
`endif

endmodule
